// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester, response and multiplier-side signals for mult_share_arbiter.
// slave is the arbiter's view; master is the clients/multiplier/environment view.
interface mult_share_arbiter_if #(
   parameter int WIDTH = 4
);
   logic               req0_valid;
   logic               req0_ready;
   logic [WIDTH-1:0]   req0_multiplier;
   logic [WIDTH-1:0]   req0_multiplicand;
   logic               req1_valid;
   logic               req1_ready;
   logic [WIDTH-1:0]   req1_multiplier;
   logic [WIDTH-1:0]   req1_multiplicand;
   logic               resp_valid;
   logic               resp_ready;
   logic               resp_id;
   logic [2*WIDTH-1:0] resp_product;
   logic               resp_err;
   logic               mult_start;
   logic [WIDTH-1:0]   mult_multiplier;
   logic [WIDTH-1:0]   mult_multiplicand;
   logic [2*WIDTH-1:0] mult_product;
   logic               mult_done;
   logic               busy;
   logic               timing_leak;

   modport slave (
      input  req0_valid, req0_multiplier, req0_multiplicand,
      input  req1_valid, req1_multiplier, req1_multiplicand,
      input  resp_ready, mult_product, mult_done,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_product, resp_err,
      output mult_start, mult_multiplier, mult_multiplicand,
      output busy, timing_leak
   );

   modport master (
      output req0_valid, req0_multiplier, req0_multiplicand,
      output req1_valid, req1_multiplier, req1_multiplicand,
      output resp_ready, mult_product, mult_done,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_product, resp_err,
      input  mult_start, mult_multiplier, mult_multiplicand,
      input  busy, timing_leak
   );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one sequential multiplier between two requesters, with a hang watchdog.
// Define MULT_TIMING_CHECK_EN to build the sticky timing_leak latency-violation detector.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester combinationally
// ISSUE | pulses mult_start, counter at 0
// WAIT  | counting cycles until mult_done or TIMEOUT
// RESP  | holding response until resp_ready
module mult_share_arbiter #(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 5,
   parameter int TIMEOUT = 15
) (
   input logic                 clk,
   input logic                 rst,
   mult_share_arbiter_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic                 ptr_q, ptr_nxt;
   logic                 id_q, id_nxt;
   logic [WIDTH-1:0]     mplr_q, mplr_nxt;
   logic [WIDTH-1:0]     mcnd_q, mcnd_nxt;
   logic [CW-1:0]        cnt_q, cnt_nxt;
   logic [2*WIDTH-1:0]   prod_q, prod_nxt;
   logic                 err_q, err_nxt;
   logic                 grant0, grant1;
   logic                 cnt_at_timeout;
   logic [CW-1:0]        cnt_inc;

   assign cnt_at_timeout = (cnt_q == CW'(TIMEOUT));
   // Saturating increment: the counter must never wrap back into the valid window.
   assign cnt_inc        = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         ptr_q  <= 1'b0;
         id_q   <= 1'b0;
         mplr_q <= '0;
         mcnd_q <= '0;
         cnt_q  <= '0;
         prod_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         ptr_q  <= ptr_nxt;
         id_q   <= id_nxt;
         mplr_q <= mplr_nxt;
         mcnd_q <= mcnd_nxt;
         cnt_q  <= cnt_nxt;
         prod_q <= prod_nxt;
         err_q  <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr_q;
      id_nxt    = id_q;
      mplr_nxt  = mplr_q;
      mcnd_nxt  = mcnd_q;
      cnt_nxt   = cnt_q;
      prod_nxt  = prod_q;
      err_nxt   = err_q;
      grant0    = 1'b0;
      grant1    = 1'b0;

      case (state)
         IDLE: begin
            // ptr_q == 0 favours requester 0 when both are valid.
            grant0 = bus.req0_valid && (!bus.req1_valid || !ptr_q);
            grant1 = bus.req1_valid && !grant0;
            if (grant0) begin
               id_nxt    = 1'b0;
               mplr_nxt  = bus.req0_multiplier;
               mcnd_nxt  = bus.req0_multiplicand;
               cnt_nxt   = '0;
               state_nxt = ISSUE;
            end else if (grant1) begin
               id_nxt    = 1'b1;
               mplr_nxt  = bus.req1_multiplier;
               mcnd_nxt  = bus.req1_multiplicand;
               cnt_nxt   = '0;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            cnt_nxt   = cnt_inc;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.mult_done) begin
               prod_nxt  = bus.mult_product;
               err_nxt   = 1'b0;
               state_nxt = RESP;
            end else if (cnt_at_timeout) begin
               prod_nxt  = '0;
               err_nxt   = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               ptr_nxt   = ~id_q;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.req0_ready        = rst & grant0;
   assign bus.req1_ready        = rst & grant1;
   assign bus.mult_start        = (state == ISSUE);
   assign bus.mult_multiplier   = mplr_q;
   assign bus.mult_multiplicand = mcnd_q;
   assign bus.resp_valid        = (state == RESP);
   assign bus.resp_id           = id_q;
   assign bus.resp_product      = prod_q;
   assign bus.resp_err          = err_q;
   assign bus.busy              = (state != IDLE);

`ifdef MULT_TIMING_CHECK_EN
   logic leak_q, leak_nxt;

   // Either an early/late answer or a hang counts as a latency violation.
   always_comb begin
      leak_nxt = leak_q;
      if (state == WAIT) begin
         if (bus.mult_done && (cnt_q != CW'(LATENCY)))
            leak_nxt = 1'b1;
         else if (!bus.mult_done && cnt_at_timeout)
            leak_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         leak_q <= 1'b0;
      else
         leak_q <= leak_nxt;
   end

   assign bus.timing_leak = leak_q;
`else
   assign bus.timing_leak = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural constant-latency multiplier model.
module tb_mult_share_arbiter;

`ifdef MULT_TIMING_CHECK_EN
   localparam logic LEAK_EN = 1'b1;
`else
   localparam logic LEAK_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   int   m_lat;
   logic m_hang;
   logic m_active;
   int   m_cnt;

   mult_share_arbiter_if #(.WIDTH(4)) mif ();

   mult_share_arbiter #(.WIDTH(4), .LATENCY(5), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: mult_done pulses m_lat cycles after the mult_start cycle.
   always @(negedge clk) begin
      if (!rst) begin
         m_active = 1'b0;
         m_cnt    = 0;
      end else if (mif.mult_start) begin
         m_active = 1'b1;
         m_cnt    = 0;
      end else if (m_active) begin
         m_cnt = m_cnt + 1;
      end
      if (m_active && !m_hang && (m_cnt == m_lat)) begin
         mif.mult_done    = 1'b1;
         mif.mult_product = 8'(mif.mult_multiplier) * 8'(mif.mult_multiplicand);
      end else begin
         mif.mult_done    = 1'b0;
         mif.mult_product = 8'hA5;
         if (m_active && !m_hang && (m_cnt > m_lat)) m_active = 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " busy"},        32'(mif.busy), 0);
      chk({nm, " mult_start"},  32'(mif.mult_start), 0);
      chk({nm, " mult_mplr"},   32'(mif.mult_multiplier), 0);
      chk({nm, " mult_mcnd"},   32'(mif.mult_multiplicand), 0);
      chk({nm, " resp_valid"},  32'(mif.resp_valid), 0);
      chk({nm, " resp_id"},     32'(mif.resp_id), 0);
      chk({nm, " resp_prod"},   32'(mif.resp_product), 0);
      chk({nm, " resp_err"},    32'(mif.resp_err), 0);
      chk({nm, " timing_leak"}, 32'(mif.timing_leak), 0);
      chk({nm, " ready0"},      32'(mif.req0_ready), 0);
      chk({nm, " ready1"},      32'(mif.req1_ready), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      mif.req0_valid = 1'b0;
      mif.req1_valid = 1'b0;
      mif.resp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b1;
   endtask

   // One full transaction from request through response handshake.
   // elat = negedges from the ISSUE cycle to the first resp_valid cycle.
   task automatic run_txn(input string nm,
                          input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                          input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                          input logic eid, input logic [7:0] eprod, input logic eerr,
                          input int elat);
      int k;
      @(negedge clk);
      mif.req0_valid        = v0;
      mif.req0_multiplier   = a0;
      mif.req0_multiplicand = b0;
      mif.req1_valid        = v1;
      mif.req1_multiplier   = a1;
      mif.req1_multiplicand = b1;
      #1;
      k = 0;
      while (!(mif.req0_ready || mif.req1_ready) && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk({nm, " ready0"}, 32'(mif.req0_ready), 32'(!eid));
      chk({nm, " ready1"}, 32'(mif.req1_ready), 32'(eid));
      @(negedge clk);
      mif.req0_valid = 1'b0;
      mif.req1_valid = 1'b0;
      chk({nm, " start"}, 32'(mif.mult_start), 1);
      chk({nm, " mplr"},  32'(mif.mult_multiplier), 32'(eid ? a1 : a0));
      chk({nm, " mcnd"},  32'(mif.mult_multiplicand), 32'(eid ? b1 : b0));
      k = 0;
      while (!mif.resp_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " latency"}, 32'(k), 32'(elat));
      chk({nm, " id"},      32'(mif.resp_id), 32'(eid));
      chk({nm, " product"}, 32'(mif.resp_product), 32'(eprod));
      chk({nm, " err"},     32'(mif.resp_err), 32'(eerr));
      mif.resp_ready = 1'b1;
      @(negedge clk);
      mif.resp_ready = 1'b0;
      chk({nm, " idle busy"},  32'(mif.busy), 0);
      chk({nm, " idle valid"}, 32'(mif.resp_valid), 0);
   endtask

   typedef struct {
      logic       v0;
      logic [3:0] a0;
      logic [3:0] b0;
      logic       v1;
      logic [3:0] a1;
      logic [3:0] b1;
      logic       eid;
      logic [7:0] eprod;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int k;
      int seen;
      checks = 0;
      errors = 0;
      m_lat  = 5;
      m_hang = 1'b0;
      m_active = 1'b0;
      m_cnt  = 0;
      rst    = 1'b0;
      mif.req0_valid = 1'b0; mif.req0_multiplier = '0; mif.req0_multiplicand = '0;
      mif.req1_valid = 1'b0; mif.req1_multiplier = '0; mif.req1_multiplicand = '0;
      mif.resp_ready = 1'b0;
      mif.mult_done  = 1'b0;
      mif.mult_product = '0;

      // Expected ids follow the round-robin pointer starting at requester 0.
      tbl[0] = '{1'b1, 4'd7,  4'd9,  1'b1, 4'd2,  4'd4,  1'b0, 8'd63};
      tbl[1] = '{1'b1, 4'd7,  4'd9,  1'b1, 4'd2,  4'd4,  1'b1, 8'd8};
      tbl[2] = '{1'b1, 4'd7,  4'd9,  1'b1, 4'd2,  4'd4,  1'b0, 8'd63};
      tbl[3] = '{1'b1, 4'd3,  4'd5,  1'b0, 4'd0,  4'd0,  1'b0, 8'd15};
      tbl[4] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd15, 4'd15, 1'b1, 8'd225};
      tbl[5] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd0,  4'd9,  1'b1, 8'd0};
      tbl[6] = '{1'b1, 4'd15, 4'd1,  1'b1, 4'd12, 4'd11, 1'b0, 8'd15};
      tbl[7] = '{1'b1, 4'd15, 4'd1,  1'b1, 4'd12, 4'd11, 1'b1, 8'd132};

      do_reset();

      for (int i = 0; i < 8; i++)
         run_txn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].a0, tbl[i].b0,
                 tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].eid, tbl[i].eprod, 1'b0, 6);

      // Backpressure: response held for 4 cycles while req1 waits.
      @(negedge clk);
      mif.req0_valid = 1'b1; mif.req0_multiplier = 4'd4; mif.req0_multiplicand = 4'd6;
      #1;
      chk("bp ready0", 32'(mif.req0_ready), 1);
      @(negedge clk);
      mif.req0_valid = 1'b0;
      k = 0;
      while (!mif.resp_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("bp latency", 32'(k), 6);
      mif.req1_valid = 1'b1; mif.req1_multiplier = 4'd2; mif.req1_multiplicand = 4'd3;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("bp hold%0d valid", i),   32'(mif.resp_valid), 1);
         chk($sformatf("bp hold%0d product", i), 32'(mif.resp_product), 24);
         chk($sformatf("bp hold%0d id", i),      32'(mif.resp_id), 0);
         chk($sformatf("bp hold%0d ready1", i),  32'(mif.req1_ready), 0);
         @(negedge clk);
      end
      mif.resp_ready = 1'b1;
      @(negedge clk);
      mif.resp_ready = 1'b0;
      #1;
      chk("bp idle busy", 32'(mif.busy), 0);
      chk("bp idle ready1", 32'(mif.req1_ready), 1);
      @(negedge clk);
      mif.req1_valid = 1'b0;
      chk("bp req1 mplr", 32'(mif.mult_multiplier), 2);
      k = 0;
      while (!mif.resp_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("bp req1 id", 32'(mif.resp_id), 1);
      chk("bp req1 product", 32'(mif.resp_product), 6);
      mif.resp_ready = 1'b1;
      @(negedge clk);
      mif.resp_ready = 1'b0;

      // Reset two cycles after mult_start drops the in-flight operation.
      @(negedge clk);
      mif.req0_valid = 1'b1; mif.req0_multiplier = 4'd9; mif.req0_multiplicand = 4'd9;
      @(negedge clk);
      mif.req0_valid = 1'b0;
      chk("rstwait start", 32'(mif.mult_start), 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk_all_zero("rstwait");
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (mif.resp_valid || mif.busy) seen++;
      end
      chk("rstwait no response", 32'(seen), 0);
      run_txn("fresh", 1'b1, 4'd15, 4'd15, 1'b0, 4'd0, 4'd0, 1'b0, 8'd225, 1'b0, 6);

      // Hung multiplier: abort after TIMEOUT WAIT cycles.
      m_hang = 1'b1;
      run_txn("hung", 1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 1'b1, 16);
      chk("hung leak", 32'(mif.timing_leak), 32'(LEAK_EN));
      m_hang = 1'b0;
      run_txn("post hung", 1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 4'd1, 1'b1, 8'd1, 1'b0, 6);
      chk("leak sticky", 32'(mif.timing_leak), 32'(LEAK_EN));

      // Early answer at counter 4: product correct, leak set only when built.
      do_reset();
      m_lat = 4;
      run_txn("early", 1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 4'd3, 1'b1, 8'd15, 1'b0, 5);
      chk("early leak", 32'(mif.timing_leak), 32'(LEAK_EN));
      m_lat = 5;
      run_txn("after early", 1'b1, 4'd2, 4'd7, 1'b0, 4'd0, 4'd0, 1'b0, 8'd14, 1'b0, 6);
      chk("early leak sticky", 32'(mif.timing_leak), 32'(LEAK_EN));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global timeout: simulation did not complete, expected finish before 300000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one constant-time sequential multiplier (start/productDone interface) between two requesters.
- Arbitrates round-robin, latches the winner's operands, and pulses the multiplier start.
- Waits for productDone, then returns the product with the requester ID on a valid/ready response channel.
- Sits between the multiplier instance and its clients. A watchdog guards against a hung multiplier.

Parameters:
- WIDTH, 4, operand width; product is 2*WIDTH.
- LATENCY, 5, expected cycles from mult_start cycle (count 0) to the mult_done cycle.
- TIMEOUT, 15, cycles in WAIT without mult_done before abort; must be greater than LATENCY.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_multiplier  input  WIDTH  requester 0 multiplier.
- req0_multiplicand  input  WIDTH  requester 0 multiplicand.
- req1_valid, req1_ready, req1_multiplier, req1_multiplicand: same as requester 0, for requester 1.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_id  output  1  requester that owns the response.
- resp_product  output  2*WIDTH  product.
- resp_err  output  1  response produced by timeout abort.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- mult_multiplier  output  WIDTH  latched multiplier operand.
- mult_multiplicand  output  WIDTH  latched multiplicand operand.
- mult_product  input  2*WIDTH  multiplier product.
- mult_done  input  1  multiplier productDone.
- busy  output  1  high in any state other than IDLE.
- timing_leak  output  1  sticky latency-violation flag.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State returns to IDLE; round-robin pointer favours requester 0.
  - All outputs are 0, including latched operands, product, and flags.
  - Reset applies mid-operation; any in-flight request is dropped with no response.
- IDLE:
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the pointer's favourite.
  - reqN_ready is combinationally high in that same cycle, for exactly one requester.
  - Latch operands and ID, go to ISSUE.
  - If no request, stay in IDLE and hold both ready low.
  - A requester dropping valid before being granted is legal and ignored.
- ISSUE:
  - mult_start=1 for exactly one cycle; cycle counter cleared to 0; go to WAIT.
- WAIT:
  - Counter increments each cycle; mult_start=0.
  - mult_multiplier and mult_multiplicand stay stable from ISSUE through the end of WAIT.
  - On mult_done: latch mult_product into resp_product, resp_err=0, go to RESP.
  - If the counter reaches TIMEOUT without mult_done: resp_product=0, resp_err=1, go to RESP.
  - mult_done outside WAIT is ignored.
- RESP:
  - resp_valid=1; resp_id, resp_product and resp_err are held stable until resp_ready=1.
  - On handshake: pointer moves to favour the other requester than resp_id, go to IDLE.
  - No new request is accepted while in RESP (single outstanding operation).
- Latency for a multiplier meeting LATENCY:
  - Accept at cycle T; mult_start at T+1; mult_done at T+1+LATENCY.
  - resp_valid first at T+2+LATENCY.
  - Earliest next accept is the cycle after the response handshake.
- Widths: product is 2*WIDTH, passed through unmodified. The arbiter performs no arithmetic beyond the counter.
- Counter width: enough bits for TIMEOUT; it saturates, never wraps.

Optional Feature:
- Macro: MULT_TIMING_CHECK_EN.
- Defined:
  - In WAIT, when mult_done arrives with counter != LATENCY, timing_leak is set.
  - A timeout also sets it.
  - Sticky until reset; does not alter the response.
- Undefined: timing_leak is tied to 0 and the comparison logic is not built.

Test Plan:
- Single request, LATENCY=5 model: req0 3*5, resp_ready=1.
  - Required: req0_ready at T, mult_start at T+1, resp_valid at T+7, resp_product=15, resp_id=0, resp_err=0.
- Simultaneous requests after reset: req0 7*9 and req1 2*4 held valid.
  - Required: responses 63 (id 0) then 8 (id 1).
  - Then both re-raised: id 0 granted again, since the pointer favours 0 after serving 1.
- Backpressure: resp_ready=0 for 4 cycles after resp_valid.
  - Required: product/id held stable; req1_valid ignored until the handshake; IDLE the cycle after.
- Reset mid-WAIT: rst=0 two cycles after mult_start.
  - Required: all outputs 0, state IDLE, no response emitted.
  - A fresh 15*15 request then returns 225.
- Hung multiplier: model never asserts mult_done.
  - Required: resp_valid with resp_err=1 and resp_product=0 after TIMEOUT=15 WAIT cycles.
  - With the macro defined, timing_leak=1.
- MULT_TIMING_CHECK_EN defined, model answers at counter 4:
  - Required: correct product returned and timing_leak=1 sticky.
  - With the macro undefined, timing_leak stays 0.
